// File: rtl/booth_pkg.sv
// Shared state encoding and ALU function codes for the Booth / shift-add multiply sequencer.
package booth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] FS_PASS = 2'b00;
  localparam logic [1:0] FS_ADD  = 2'b01;
  localparam logic [1:0] FS_SUB  = 2'b10;

endpackage

// File: rtl/iter_counter.sv
// Loadable iteration down-counter; loads WIDTH, steps down on dec, never wraps below zero.
// zero_nxt flags that the current decrement is the last one.
module iter_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero_nxt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero_nxt = (count == CW'(1));

endmodule

// File: rtl/booth_sequencer.sv
// Control sequencer for a WIDTH-iteration shift-add / radix-2 Booth multiplier; done 2*WIDTH+2 cycles after start.
// No backpressure: start is only honoured in IDLE and is dropped (never queued) while busy.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         X0,
  input  logic                         Xm1,
  output logic                         WEN,
  output logic                         SEL,
  output logic [1:0]                   FS,
  output logic                         SHIFT,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  state_t state_q;
  state_t state_d;
  logic   mode_q;
  logic   last_iter;

  iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .clk      (CLK),
    .rst_n    (reset_n),
    .load     (state_q == ST_LOAD),
    .dec      (state_q == ST_SHIFT),
    .count    (count),
    .zero_nxt (last_iter)
  );

  // mode is captured together with start so mid-operation changes cannot alter the decode
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        mode_q <= mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = ST_EVAL;
      ST_EVAL:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = last_iter ? ST_DONE : ST_EVAL;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    WEN   = 1'b0;
    SEL   = 1'b0;
    FS    = FS_PASS;
    SHIFT = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        WEN  = 1'b1;
        busy = 1'b1;
      end
      ST_EVAL: begin
        SEL  = 1'b1;
        busy = 1'b1;
        // Booth looks at the {Q0,Q-1} pair; shift-add only at Q0
        if (mode_q) begin
          case ({X0, Xm1})
            2'b01:   begin FS = FS_ADD; WEN = 1'b1; end
            2'b10:   begin FS = FS_SUB; WEN = 1'b1; end
            default: begin FS = FS_PASS; WEN = 1'b0; end
          endcase
        end else if (X0) begin
          FS  = FS_ADD;
          WEN = 1'b1;
        end
      end
      ST_SHIFT: begin
        SHIFT = 1'b1;
        SEL   = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Randomised bench for booth_sequencer at WIDTH=8 and WIDTH=1 against a cycle-offset reference model.
module tb_booth_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       mode;
  logic       x0;
  logic       xm1;

  logic [1:0] wen, sel, shf, bsy, dn;
  logic [1:0] fs8, fs1;
  logic [3:0] cnt8;
  logic [0:0] cnt1;

  int n_cmp;
  int n_bad;

  // Model: per instance, whether a multiply is in flight, the cycle offset t
  // since the accepting edge (1 = first cycle after it), and the mode captured at start.
  localparam int WS [2] = '{8, 1};
  bit act [2];
  int t   [2];
  bit ml  [2];

  typedef struct packed {
    logic       wen;
    logic       sel;
    logic [1:0] fs;
    logic       shift;
    logic       busy;
    logic       done;
    logic [7:0] count;
  } outs_t;

  booth_sequencer #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .reset_n(reset_n), .start(start), .mode(mode), .X0(x0), .Xm1(xm1),
    .WEN(wen[0]), .SEL(sel[0]), .FS(fs8), .SHIFT(shf[0]), .busy(bsy[0]), .done(dn[0]),
    .count(cnt8)
  );

  booth_sequencer #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .reset_n(reset_n), .start(start), .mode(mode), .X0(x0), .Xm1(xm1),
    .WEN(wen[1]), .SEL(sel[1]), .FS(fs1), .SHIFT(shf[1]), .busy(bsy[1]), .done(dn[1]),
    .count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t observed(int i);
    outs_t o;
    o.wen   = wen[i];
    o.sel   = sel[i];
    o.fs    = (i == 0) ? fs8 : fs1;
    o.shift = shf[i];
    o.busy  = bsy[i];
    o.done  = dn[i];
    o.count = (i == 0) ? 8'(cnt8) : 8'(cnt1);
    return o;
  endfunction

  // Cycle 1 loads, even cycles 2..2W evaluate iteration t/2, odd cycles 3..2W+1 shift,
  // cycle 2W+2 signals done; count shows the iterations not yet shifted.
  function automatic outs_t expected(int i);
    outs_t e;
    int w;
    int j;
    e = '0;
    w = WS[i];
    if (act[i]) begin
      if (t[i] == 1) begin
        e.wen  = 1'b1;
        e.busy = 1'b1;
      end else if (t[i] <= 2 * w + 1) begin
        j       = t[i] / 2;
        e.count = 8'(w - j + 1);
        e.sel   = 1'b1;
        e.busy  = 1'b1;
        if (t[i] % 2 == 1) begin
          e.shift = 1'b1;
        end else if (ml[i]) begin
          if (x0 && !xm1)      begin e.fs = 2'd2; e.wen = 1'b1; end
          else if (!x0 && xm1) begin e.fs = 2'd1; e.wen = 1'b1; end
        end else if (x0) begin
          e.fs  = 2'd1;
          e.wen = 1'b1;
        end
      end else begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check_dut(input int i);
    outs_t o;
    outs_t e;
    string p;
    o = observed(i);
    e = expected(i);
    p = $sformatf("w%0d t=%0d", WS[i], t[i]);
    chk({p, " WEN"},   32'(o.wen),   32'(e.wen));
    chk({p, " SEL"},   32'(o.sel),   32'(e.sel));
    chk({p, " FS"},    32'(o.fs),    32'(e.fs));
    chk({p, " SHIFT"}, 32'(o.shift), 32'(e.shift));
    chk({p, " busy"},  32'(o.busy),  32'(e.busy));
    chk({p, " done"},  32'(o.done),  32'(e.done));
    chk({p, " count"}, 32'(o.count), 32'(e.count));
  endtask

  task automatic advance(input int i);
    if (!reset_n) begin
      act[i] = 1'b0;
      t[i]   = 0;
    end else if (act[i]) begin
      if (t[i] == 2 * WS[i] + 2) begin
        act[i] = 1'b0;
        t[i]   = 0;
      end else begin
        t[i]++;
      end
    end else if (start) begin
      act[i] = 1'b1;
      t[i]   = 1;
      ml[i]  = mode;
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    advance(0);
    advance(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < 40) begin
      step();
      k++;
    end
    chk("idle reached within budget", 32'(act[0] || act[1]), 32'd0);
  endtask

  initial begin
    int k;
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    x0      = 1'b0;
    xm1     = 1'b0;
    act     = '{0, 0};
    t       = '{0, 0};
    ml      = '{0, 0};

    #2;
    check_dut(0);
    check_dut(1);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();

    // Booth, {X0,Xm1}=10 held: subtract on every evaluation
    mode  = 1'b1;
    x0    = 1'b1;
    xm1   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    mode  = 1'b0;
    repeat (20) step();

    // shift-add, X0=0 held: only the load writes
    x0    = 1'b0;
    xm1   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    mode  = 1'b1;
    repeat (20) step();

    // start held high: back-to-back multiplies through IDLE, random mode/operand bits
    start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      mode = 1'($urandom);
      x0   = 1'($urandom);
      xm1  = 1'($urandom);
      step();
    end
    start = 1'b0;

    // random start requests, mode toggling freely mid-operation
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
      x0    = 1'($urandom);
      xm1   = 1'($urandom);
      step();
    end
    start = 1'b0;
    wait_idle();

    // asynchronous reset during the 5th shift of the WIDTH=8 instance
    mode  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(act[0] && t[0] == 11) && k < 40) begin
      x0  = 1'($urandom);
      xm1 = 1'($urandom);
      step();
      k++;
    end
    chk("reached 5th shift", 32'(act[0] && t[0] == 11), 32'd1);
    #1 reset_n = 1'b0;
    act = '{0, 0};
    t   = '{0, 0};
    #1;
    check_dut(0);
    check_dut(1);
    repeat (2) step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      x0   = 1'($urandom);
      mode = 1'($urandom);
      step();
    end

    // more random traffic after the reset
    for (int c = 0; c < 300; c++) begin
      start = ($urandom_range(0, 2) == 0);
      mode  = 1'($urandom);
      x0    = 1'($urandom);
      xm1   = 1'($urandom);
      step();
    end
    start = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
